// File: rtl/multdiv_pkg.sv
// Shared types and sizing helpers for the iterative multiply/divide unit.
package multdiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_e;

    // Iteration counter must be able to hold the value WIDTH.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/multdiv_addsub.sv
// N-bit add/subtract with a parallel-prefix (Kogge-Stone) carry-lookahead network.
module multdiv_addsub #(
    parameter int unsigned N = 33
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum
);

    always_comb begin : cla
        logic [N-1:0] bx, p, g, gk, pk, gn, pn, c;
        bx = sub ? ~b : b;
        p  = a ^ bx;
        g  = a & bx;
        gk = g;
        pk = p;
        // Fold carry-in into bit 0 so gk[i] becomes the carry out of bit i.
        gk[0] = g[0] | (p[0] & sub);
        for (int unsigned d = 1; d < N; d = d * 2) begin
            gn = gk;
            pn = pk;
            for (int unsigned i = d; i < N; i++) begin
                gn[i] = gk[i] | (pk[i] & gk[i-d]);
                pn[i] = pk[i] & pk[i-d];
            end
            gk = gn;
            pk = pn;
        end
        c   = {gk[N-2:0], sub};
        sum = p ^ c;
    end

endmodule

// File: rtl/multdiv_iter.sv
// Iterative radix-2 shift-add multiplier / restoring divider sharing one adder.
module multdiv_iter
    import multdiv_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter bit SIGNED = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             flush,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
    logic             a_neg_q, a_neg_d, b_neg_q, b_neg_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             exc_q, exc_d, rdy_q, rdy_d;

    logic             start, res_neg, a_neg_in, b_neg_in;
    logic [WIDTH-1:0] a_mag_in, b_mag_in;
    logic [WIDTH:0]   add_a, add_b, add_s, mul_acc;
    logic             add_sub;

    assign start    = !reset && !flush && (state_q == IDLE) && (ctrl_MULT || ctrl_DIV);
    assign busy     = start || (!reset && (state_q == MUL || state_q == DIV));
    assign a_neg_in = SIGNED & data_operandA[WIDTH-1];
    assign b_neg_in = SIGNED & data_operandB[WIDTH-1];
    assign a_mag_in = a_neg_in ? '0 - data_operandA : data_operandA;
    assign b_mag_in = b_neg_in ? '0 - data_operandB : data_operandB;
    assign res_neg  = a_neg_q ^ b_neg_q;

    assign data_result    = res_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

    // hi_q is the product high half in MUL and the partial remainder in DIV.
    always_comb begin
        add_a   = {1'b0, hi_q};
        add_b   = {1'b0, opb_q};
        add_sub = 1'b0;
        if (state_q == DIV) begin
            add_a   = {hi_q, lo_q[WIDTH-1]};
            add_sub = 1'b1;
        end
    end

    multdiv_addsub #(.N(WIDTH + 1)) u_addsub (
        .a  (add_a),
        .b  (add_b),
        .sub(add_sub),
        .sum(add_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opb_d   = opb_q;
        a_neg_d = a_neg_q;
        b_neg_d = b_neg_q;
        res_d   = res_q;
        exc_d   = exc_q;
        rdy_d   = 1'b0;
        mul_acc = lo_q[0] ? add_s : {1'b0, hi_q};

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ctrl_MULT ? MUL : DIV;
                    cnt_d   = '0;
                    hi_d    = '0;
                    lo_d    = a_mag_in;
                    opb_d   = b_mag_in;
                    a_neg_d = a_neg_in;
                    b_neg_d = b_neg_in;
                end
            end
            MUL: begin
                hi_d  = mul_acc[WIDTH:1];
                lo_d  = {mul_acc[0], lo_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                    rdy_d   = 1'b1;
                    res_d   = res_neg ? '0 - lo_d : lo_d;
                    if (!SIGNED)
                        exc_d = |hi_d;
                    else if (res_neg)
                        exc_d = (|hi_d) || (lo_d[WIDTH-1] && (|lo_d[WIDTH-2:0]));
                    else
                        exc_d = (|hi_d) || lo_d[WIDTH-1];
                end
            end
            DIV: begin
                if (opb_q == '0) begin
                    state_d = DONE;
                    rdy_d   = 1'b1;
                    res_d   = '0;
                    exc_d   = 1'b1;
                end else begin
                    hi_d  = add_s[WIDTH] ? add_a[WIDTH-1:0] : add_s[WIDTH-1:0];
                    lo_d  = {lo_q[WIDTH-2:0], ~add_s[WIDTH]};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_ITER) begin
                        state_d = DONE;
                        rdy_d   = 1'b1;
                        res_d   = res_neg ? '0 - lo_d : lo_d;
                        exc_d   = SIGNED & ~res_neg & lo_d[WIDTH-1];
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d = IDLE;
            rdy_d   = 1'b0;
            res_d   = res_q;
            exc_d   = exc_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opb_q   <= '0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            res_q   <= '0;
            exc_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opb_q   <= opb_d;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
            rdy_q   <= rdy_d;
        end
    end

endmodule
